ex_mdu: RTL

- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes EX-stage operands and the decoded MDU operation, and owns the architectural HI/LO registers.
- Drives a stall request to the hazard logic so that later MDU instructions, and HI/LO reads, wait until the current operation finishes.

---
 rtl/ex_mdu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit for the EX stage; owns HI/LO.
// Radix-2 shift-add multiply and restoring divide, one step per negedge,
// with a final sign-fix cycle that writes HI/LO.
// Optional build macro MDU_EARLY_EXIT_EN: a multiply finishes as soon as the
// remaining multiplier bits are all zero (divide timing is unchanged).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an MDU op; MTHI/MTLO write HI/LO directly
// MUL   | one shift-add step per edge over the 64-bit product
// DIV   | one restoring step per edge on remainder:quotient
// FIX   | apply result signs / divide-by-zero value, write HI/LO
module ex_mdu #(
    parameter int data_size = 32,
    parameter int cnt_size  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EX_MDU_start,
    input  logic [2:0]           EX_MDU_op,
    input  logic [data_size-1:0] EX_Rs_data,
    input  logic [data_size-1:0] EX_Rt_data,
    input  logic                 EX_mf_req,
    input  logic                 EX_mf_hi,
    output logic [data_size-1:0] MDU_out,
    output logic                 MDU_busy,
    output logic                 MDU_stall,
    output logic                 MDU_done
);

    localparam int W  = data_size;
    localparam int W2 = 2 * data_size;
    localparam logic [cnt_size-1:0] CNT_LAST = cnt_size'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        hi_q, hi_d, lo_q, lo_d;
    logic [W2-1:0]       mcand_q, mcand_d;   // shifted multiplicand; raw dividend during DIV
    logic [W-1:0]        opb_q, opb_d;       // multiplier (shifts right) or divisor
    logic [W2-1:0]       acc_q, acc_d;       // product, or remainder:quotient
    logic [cnt_size-1:0] cnt_q, cnt_d;
    logic                qneg_q, qneg_d, rneg_q, rneg_d;
    logic                is_div_q, is_div_d;
    logic                done_q, done_d;

    logic                op_signed;
    logic [W-1:0]        a_abs, b_abs;
    logic [W2-1:0]       mul_acc, prod_fix;
    logic [W:0]          rem_sh, diff;
    logic                no_borrow;
    logic [W-1:0]        rem_new, quot_fix, rem_fix;
    logic [W2-1:0]       div_acc;

    assign op_signed = (EX_MDU_op == 3'd0) || (EX_MDU_op == 3'd2);
    assign a_abs     = (op_signed && EX_Rs_data[W-1]) ? -EX_Rs_data : EX_Rs_data;
    assign b_abs     = (op_signed && EX_Rt_data[W-1]) ? -EX_Rt_data : EX_Rt_data;

    assign mul_acc   = opb_q[0] ? (acc_q + mcand_q) : acc_q;

    // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
    assign rem_sh    = acc_q[W2-1:W-1];
    assign diff      = rem_sh - {1'b0, opb_q};
    assign no_borrow = ~diff[W];
    assign rem_new   = no_borrow ? diff[W-1:0] : rem_sh[W-1:0];
    assign div_acc   = {rem_new, acc_q[W-2:0], no_borrow};

    assign prod_fix  = qneg_q ? -acc_q : acc_q;
    assign quot_fix  = qneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix   = rneg_q ? -acc_q[W2-1:W] : acc_q[W2-1:W];

    assign MDU_out   = EX_mf_hi ? hi_q : lo_q;
    assign MDU_busy  = (state_q != S_IDLE);
    assign MDU_stall = MDU_busy & (EX_MDU_start | EX_mf_req);
    assign MDU_done  = done_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (EX_MDU_start) begin
                    case (EX_MDU_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d  = EX_MDU_op[1] ? S_DIV : S_MUL;
                            is_div_d = EX_MDU_op[1];
                            // DIV keeps the raw dividend for the divide-by-zero HI value,
                            // and starts with |A| in the quotient half of the accumulator.
                            mcand_d  = EX_MDU_op[1] ? {{W{1'b0}}, EX_Rs_data} : {{W{1'b0}}, a_abs};
                            acc_d    = EX_MDU_op[1] ? {{W{1'b0}}, a_abs} : '0;
                            opb_d    = b_abs;
                            cnt_d    = '0;
                            qneg_d   = op_signed & (EX_Rs_data[W-1] ^ EX_Rt_data[W-1]);
                            rneg_d   = (EX_MDU_op == 3'd2) & EX_Rs_data[W-1];
                        end
                        3'd4:    hi_d = EX_Rs_data;
                        3'd5:    lo_d = EX_Rs_data;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d   = mul_acc;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + cnt_size'(1);
`ifdef MDU_EARLY_EXIT_EN
                if ((cnt_q == CNT_LAST) || (opb_q[W-1:1] == '0)) state_d = S_FIX;
`else
                if (cnt_q == CNT_LAST) state_d = S_FIX;
`endif
            end
            S_DIV: begin
                acc_d = div_acc;
                cnt_d = cnt_q + cnt_size'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (opb_q == '0) begin
                        lo_d = '1;
                        hi_d = mcand_q[W-1:0];
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, updated on the pipeline's negedge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            done_q   <= done_d;
        end
    end

endmodule
